// File: rtl/i2c_slave_regs_if.sv
// rtl/i2c_slave_regs_if.sv - I2C pad bundle between bus master and register slave
interface i2c_slave_regs_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe;

    modport master (output scl_i, output sda_i, input sda_oe);
    modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - oversampled I2C slave with byte register file and host read port
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NUM_REGS   = 16,
    parameter logic [7:0] RST_VAL    = 8'h00,
    localparam int        RA_W       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    i2c_slave_regs_if.slave  bus,
    input  logic [RA_W-1:0]  host_ra,
    output logic [7:0]       host_rd,
    output logic             wr_stb,
    output logic [7:0]       wr_idx,
    output logic [7:0]       wr_byte,
    output logic             busy,
    output logic             start_det,
    output logic             stop_det
);
    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      scl_q, scl_d, sda_q, sda_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [6:0]      sr_q, sr_d;
    logic [7:0]      tx_q, tx_d;
    logic [RA_W-1:0] ptr_q, ptr_d;
    logic            rw_q, rw_d, mack_q, mack_d;
    logic            sda_oe_q, sda_oe_d;
    logic            wr_stb_q, wr_stb_d;
    logic [7:0]      wr_idx_q, wr_idx_d, wr_byte_q, wr_byte_d;
    logic            start_q, start_d, stop_q, stop_d;
    logic [7:0]      regs_q [NUM_REGS];
    logic [7:0]      regs_d [NUM_REGS];

    logic            scl_rise, scl_fall, start_c, stop_c, sda_s;
    logic [7:0]      byte_in;
    logic [RA_W-1:0] ptr_inc;
    logic [8:0]      ra_ext;

    // [0],[1] form the synchronizer, [2] is the previous synchronized sample
    assign sda_s    = sda_q[1];
    assign scl_rise = scl_q[1] & ~scl_q[2];
    assign scl_fall = ~scl_q[1] & scl_q[2];
    assign start_c  = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
    assign stop_c   = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    assign byte_in  = {sr_q, sda_s};
    assign ptr_inc  = (32'(ptr_q) == NUM_REGS - 1) ? '0 : ptr_q + RA_W'(1);

    always_comb begin
        scl_d     = {scl_q[1:0], bus.scl_i};
        sda_d     = {sda_q[1:0], bus.sda_i};
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        mack_d    = mack_q;
        sda_oe_d  = sda_oe_q;
        wr_stb_d  = 1'b0;
        wr_idx_d  = wr_idx_q;
        wr_byte_d = wr_byte_q;
        start_d   = start_c;
        stop_d    = stop_c;
        regs_d    = regs_q;

        // Bus conditions override any bit sampled in the same cycle
        if (start_c) begin
            state_d  = DEV_ADDR;
            cnt_d    = 3'd7;
            sda_oe_d = 1'b0;
            mack_d   = 1'b0;
        end else if (stop_c) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
        end else begin
            if (scl_rise) begin
                sr_d  = byte_in[6:0];
                cnt_d = cnt_q - 3'd1;
            end
            unique case (state_q)
                IDLE: ;
                DEV_ADDR: if (scl_rise && cnt_q == 3'd0) begin
                    if (byte_in[7:1] == SLAVE_ADDR) begin
                        state_d = DEV_ACK;
                        rw_d    = byte_in[0];
                    end else begin
                        state_d = IDLE;
                    end
                end
                // Slave ACK slots: first fall pulls SDA, second fall releases and moves on
                DEV_ACK, REG_ACK, WR_ACK: if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 3'd7;
                        if (state_q == DEV_ACK && rw_q) begin
                            state_d  = RD_DATA;
                            tx_d     = regs_q[ptr_q];
                            sda_oe_d = ~regs_q[ptr_q][7];
                        end else if (state_q == DEV_ACK) begin
                            state_d = REG_ADDR;
                        end else begin
                            state_d = WR_DATA;
                        end
                    end
                end
                REG_ADDR: if (scl_rise && cnt_q == 3'd0) begin
                    if ({1'b0, byte_in} < 9'(NUM_REGS)) begin
                        ptr_d   = RA_W'(byte_in);
                        state_d = REG_ACK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WR_DATA: if (scl_rise && cnt_q == 3'd0) begin
                    regs_d[ptr_q] = byte_in;
                    wr_stb_d      = 1'b1;
                    wr_idx_d      = 8'(ptr_q);
                    wr_byte_d     = byte_in;
                    ptr_d         = ptr_inc;
                    state_d       = WR_ACK;
                end
                RD_DATA: begin
                    if (scl_rise && cnt_q == 3'd0)
                        state_d = RD_ACK;
                    else if (scl_fall)
                        sda_oe_d = ~tx_q[cnt_q];
                end
                RD_ACK: begin
                    if (scl_fall) begin
                        if (mack_q) begin
                            state_d  = RD_DATA;
                            tx_d     = regs_q[ptr_q];
                            sda_oe_d = ~regs_q[ptr_q][7];
                            cnt_d    = 3'd7;
                            mack_d   = 1'b0;
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end else if (scl_rise) begin
                        ptr_d = ptr_inc;
                        if (!sda_s) mack_d = 1'b1;
                        else        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            scl_q     <= 3'b111;
            sda_q     <= 3'b111;
            cnt_q     <= 3'd7;
            sr_q      <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            mack_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_idx_q  <= '0;
            wr_byte_q <= '0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
        end else begin
            state_q   <= state_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            mack_q    <= mack_d;
            sda_oe_q  <= sda_oe_d;
            wr_stb_q  <= wr_stb_d;
            wr_idx_q  <= wr_idx_d;
            wr_byte_q <= wr_byte_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            regs_q    <= regs_d;
        end
    end

    assign ra_ext     = 9'(host_ra);
    assign host_rd    = (ra_ext < 9'(NUM_REGS)) ? regs_q[host_ra] : 8'h00;
    assign bus.sda_oe = sda_oe_q;
    assign wr_stb     = wr_stb_q;
    assign wr_idx     = wr_idx_q;
    assign wr_byte    = wr_byte_q;
    assign busy       = (state_q != IDLE);
    assign start_det  = start_q;
    assign stop_det   = stop_q;
endmodule
